fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the RV32I core, replacing the always-on single-cycle fetch path. It issues sequential requests to instruction memory with arbitrary in-order response latency, buffers returned words and their PCs in a Depth-entry queue, and presents them to decode with a valid/ready handshake. A taken jump or branch from execute flushes the queue and discards in-flight responses.

---
 rtl/fetch_queue_if.sv | 35 +++
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Bundles the fetch front end's three conversations: the instruction-memory
// request/response bus, the redirect from execute, and the decode handshake.
//   master : the fetch queue side (drives requests and the decode outputs)
//   slave  : the environment side (memory, execute and decode)
// Signals:
//   instr_read / instr_addr    request strobe and word-aligned address
//   instr_valid / instr_out    in-order response strobe and word
//   jump_flag / jump_address   redirect from execute
//   id_valid / id_instr / id_pc / id_ready   decode handshake
interface fetch_queue_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 instr_read;
  logic [AddrWidth-1:0] instr_addr;
  logic                 instr_valid;
  logic [DataWidth-1:0] instr_out;
  logic                 jump_flag;
  logic [AddrWidth-1:0] jump_address;
  logic                 id_valid;
  logic [DataWidth-1:0] id_instr;
  logic [AddrWidth-1:0] id_pc;
  logic                 id_ready;

  modport master (
    output instr_read, instr_addr, id_valid, id_instr, id_pc,
    input  instr_valid, instr_out, jump_flag, jump_address, id_ready
  );

  modport slave (
    input  instr_read, instr_addr, id_valid, id_instr, id_pc,
    output instr_valid, instr_out, jump_flag, jump_address, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end for the RV32I core. Issues sequential word
// requests to instruction memory, buffers the in-order responses together
// with their PCs in a Depth-entry queue and hands them to decode through a
// valid/ready handshake. A redirect from execute flushes the queue and drops
// every response that is still in flight.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fetch_queue_if.master (memory bus, redirect, decode handshake)
// Option:
//   FETCH_QUEUE_BYPASS_EN  when defined, a live response arriving while the
//   queue is empty is presented to decode in the same cycle.
module fetch_queue #(
  parameter int                   AddrWidth   = 32,
  parameter int                   DataWidth   = 32,
  parameter int                   Depth       = 4,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = PtrWidth + 1;
  localparam logic [CntWidth:0] DepthLimit = (CntWidth + 1)'(Depth);
  localparam logic [AddrWidth-1:0] WordStep = AddrWidth'(4);

  logic [AddrWidth-1:0] fetch_pc;
  logic [AddrWidth-1:0] resp_pc;
  logic [CntWidth-1:0]  count;
  logic [CntWidth-1:0]  outstanding;
  logic [CntWidth-1:0]  discard;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [PtrWidth-1:0]  wr_ptr;
  logic [DataWidth-1:0] instr_mem [Depth];
  logic [AddrWidth-1:0] pc_mem [Depth];

  logic [CntWidth:0] in_use;
  logic              issue;
  logic              live_resp;
  logic              queue_valid;
  logic              pop;
  logic              push;
  logic              bypass_take;

  // Credits cover both buffered words and words still in flight, so a
  // response can never land on a full queue.
  assign in_use      = {1'b0, count} + {1'b0, outstanding};
  assign issue       = !rst && !bus.jump_flag && (in_use < DepthLimit);
  assign live_resp   = bus.instr_valid && (discard == '0) && !bus.jump_flag;
  assign queue_valid = (count != '0) && !bus.jump_flag;
  assign pop         = queue_valid && bus.id_ready;
  assign push        = live_resp && !bypass_take;

  assign bus.instr_read = issue;
  assign bus.instr_addr = fetch_pc;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue lets the live response go straight to decode; it is only
  // buffered if decode does not take it this cycle.
  logic bypass_active;
  assign bypass_active = live_resp && (count == '0);
  assign bypass_take   = bypass_active && bus.id_ready;
  assign bus.id_valid  = queue_valid || bypass_active;
  assign bus.id_instr  = bypass_active ? bus.instr_out : instr_mem[rd_ptr];
  assign bus.id_pc     = bypass_active ? resp_pc : pc_mem[rd_ptr];
`else
  assign bypass_take  = 1'b0;
  assign bus.id_valid = queue_valid;
  assign bus.id_instr = instr_mem[rd_ptr];
  assign bus.id_pc    = pc_mem[rd_ptr];
`endif

  // Storage is cleared on reset so the head outputs read 0 / ResetVector
  // before anything has been fetched. A redirect keeps outstanding intact
  // (those requests are still owed a response) and turns all of them, less
  // any arriving this cycle, into words to discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= ResetVector;
      resp_pc     <= ResetVector;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < Depth; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= ResetVector;
      end
    end else begin
      outstanding <= outstanding + CntWidth'(issue) - CntWidth'(bus.instr_valid);
      if (bus.jump_flag) begin
        fetch_pc <= bus.jump_address;
        resp_pc  <= bus.jump_address;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        discard  <= outstanding - CntWidth'(bus.instr_valid);
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + WordStep;
        end
        if (live_resp) begin
          resp_pc <= resp_pc + WordStep;
        end
        if (bus.instr_valid && (discard != '0)) begin
          discard <= discard - CntWidth'(1);
        end
        if (push) begin
          instr_mem[wr_ptr] <= bus.instr_out;
          pc_mem[wr_ptr]    <= resp_pc;
          wr_ptr            <= wr_ptr + PtrWidth'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PtrWidth'(1);
        end
        count <= count + CntWidth'(push) - CntWidth'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed bench for fetch_queue (Depth 4, ResetVector 0). An instruction
// memory with selectable fixed latency answers every request; the word
// stored at an address is addr ^ 32'h13579BDF. Scenarios: reset values,
// backpressure, streaming, redirect with requests in flight, address
// wrap-around and (with FETCH_QUEUE_BYPASS_EN) same-cycle bypass.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   lat = 1;
  int   checks = 0;
  int   passes = 0;

  logic        pipe_v [8];
  logic [31:0] pipe_a [8];

  fetch_queue_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  fetch_queue #(
    .AddrWidth  (32),
    .DataWidth  (32),
    .Depth      (4),
    .ResetVector(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h13579BDF;
  endfunction

  // Fixed-latency memory: a request seen in cycle N answers in cycle N+lat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= bus.instr_read;
      pipe_a[0] <= bus.instr_addr;
      for (int i = 1; i < 8; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign bus.instr_valid = pipe_v[lat-1];
  assign bus.instr_out   = mem_word(pipe_a[lat-1]);

  // Advance one cycle: new inputs at the falling edge, outputs sampled 1 ns later.
  task automatic applyStimulus(input logic jf, input logic [31:0] ja, input logic rdy);
    @(negedge clk);
    bus.jump_flag    = jf;
    bus.jump_address = ja;
    bus.id_ready     = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  // Holds reset for three cycles, checks reset outputs, then releases it so
  // the sample point on return is the first cycle out of reset.
  task automatic resetDut(input int latency, input logic rdy);
    rst              = 1'b1;
    lat              = latency;
    bus.jump_flag    = 1'b0;
    bus.jump_address = '0;
    bus.id_ready     = rdy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset instr_read", 32'(bus.instr_read), 32'd0);
    checkOutput("reset instr_addr", bus.instr_addr, 32'h0);
    checkOutput("reset id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("reset id_pc", bus.id_pc, 32'h0);
    checkOutput("reset id_instr", bus.id_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Steps until id_valid is seen or the budget runs out.
  task automatic waitValid(input string tag, input int limit, output int steps);
    steps = 0;
    do begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      steps++;
    end while (!bus.id_valid && steps < limit);
    checkOutput(tag, 32'(bus.id_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wrap_pc[$];
    logic [31:0] wrap_instr[$];
    logic [31:0] wrap_req[3];
    logic        byp;
    int          steps;

`ifdef FETCH_QUEUE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif

    // Backpressure then streaming, latency 1.
    resetDut(1, 1'b0);
    checkOutput("c0 instr_read", 32'(bus.instr_read), 32'd1);
    checkOutput("c0 instr_addr", bus.instr_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("c1 instr_addr", bus.instr_addr, 32'h4);
    checkOutput("c1 id_valid", 32'(bus.id_valid), 32'(byp));
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("c2 instr_addr", bus.instr_addr, 32'h8);
    checkOutput("c2 id_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("c2 id_pc", bus.id_pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("c3 instr_read", 32'(bus.instr_read), 32'd1);
    checkOutput("c3 instr_addr", bus.instr_addr, 32'hC);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("c4 full instr_read", 32'(bus.instr_read), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("c5 full instr_read", 32'(bus.instr_read), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("c6 instr_read", 32'(bus.instr_read), 32'd0);
    checkOutput("c6 id_pc", bus.id_pc, 32'h0);
    checkOutput("c6 id_instr", bus.id_instr, mem_word(32'h0));
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("c7 resume instr_read", 32'(bus.instr_read), 32'd1);
    checkOutput("c7 resume instr_addr", bus.instr_addr, 32'h10);
    checkOutput("c7 id_pc", bus.id_pc, 32'h4);
    for (int k = 2; k < 12; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("stream id_valid %0d", k), 32'(bus.id_valid), 32'd1);
      checkOutput($sformatf("stream id_pc %0d", k), bus.id_pc, 32'(4 * k));
      checkOutput($sformatf("stream id_instr %0d", k), bus.id_instr, mem_word(32'(4 * k)));
    end

    // Redirect to 0x100 with two requests in flight, latency 3.
    resetDut(3, 1'b1);
    checkOutput("redir c0 instr_addr", bus.instr_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir c1 instr_addr", bus.instr_addr, 32'h4);
    applyStimulus(1'b1, 32'h100, 1'b1);
    checkOutput("redir c2 instr_read", 32'(bus.instr_read), 32'd0);
    checkOutput("redir c2 id_valid", 32'(bus.id_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir c3 instr_read", 32'(bus.instr_read), 32'd1);
    checkOutput("redir c3 instr_addr", bus.instr_addr, 32'h100);
    checkOutput("redir c3 id_valid", 32'(bus.id_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir c4 instr_addr", bus.instr_addr, 32'h104);
    checkOutput("redir c4 id_valid", 32'(bus.id_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir c5 instr_addr", bus.instr_addr, 32'h108);
    checkOutput("redir c5 id_valid", 32'(bus.id_valid), 32'd0);
    waitValid("redir first valid", 10, steps);
    checkOutput("redir first latency", 32'(steps), byp ? 32'd1 : 32'd2);
    checkOutput("redir first id_pc", bus.id_pc, 32'h100);
    checkOutput("redir first id_instr", bus.id_instr, mem_word(32'h100));
    waitValid("redir second valid", 10, steps);
    checkOutput("redir second id_pc", bus.id_pc, 32'h104);
    waitValid("redir third valid", 10, steps);
    checkOutput("redir third id_pc", bus.id_pc, 32'h108);
    checkOutput("redir third id_instr", bus.id_instr, mem_word(32'h108));

    // Wrap-around redirect while a response arrives in the same cycle.
    resetDut(1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    checkOutput("wrap jump id_valid", 32'(bus.id_valid), 32'd0);
    wrap_req[0] = 32'hFFFF_FFF8;
    wrap_req[1] = 32'hFFFF_FFFC;
    wrap_req[2] = 32'h0000_0000;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (k < 3) begin
        checkOutput($sformatf("wrap instr_read %0d", k), 32'(bus.instr_read), 32'd1);
        checkOutput($sformatf("wrap instr_addr %0d", k), bus.instr_addr, wrap_req[k]);
      end
      if (bus.id_valid) begin
        wrap_pc.push_back(bus.id_pc);
        wrap_instr.push_back(bus.id_instr);
      end
    end
    checkOutput("wrap enough pops", 32'(wrap_pc.size() >= 3), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k < wrap_pc.size()) begin
        checkOutput($sformatf("wrap id_pc %0d", k), wrap_pc[k], wrap_req[k]);
        checkOutput($sformatf("wrap id_instr %0d", k), wrap_instr[k], mem_word(wrap_req[k]));
      end
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    // Same-cycle bypass on an empty queue.
    resetDut(1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bypass id_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("bypass id_pc", bus.id_pc, 32'h0);
    checkOutput("bypass id_instr", bus.id_instr, mem_word(32'h0));
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bypass count", 32'(dut.count), 32'd0);
    checkOutput("bypass next id_pc", bus.id_pc, 32'h4);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
